// File: rtl/cache_pkg.sv
// Shared cache definitions: block geometry, address field split and the
// fill controller state encoding.
package cache_pkg;

    localparam int BLOCK_WORDS   = 8;
    localparam int OFFSET_W      = $clog2(BLOCK_WORDS);
    localparam int BYTE_OFFSET_W = OFFSET_W + 1;
    localparam int CACHE_ADDR_W  = 16;
    localparam int INDEX_W       = 4;
    localparam int TAG_W         = CACHE_ADDR_W - INDEX_W - BYTE_OFFSET_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm.sv
// Miss-handling fill controller: requests a whole block from main memory,
// streams returned words into the data array and writes the tag on the last word.
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_W-1:0]              miss_address,
    input  logic                           memory_data_valid,
    input  logic [DATA_W-1:0]              memory_data,
    output logic                           fsm_busy,
    output logic                           mem_req,
    output logic [ADDR_W-1:0]              memory_address,
    output logic                           write_data_array,
    output logic                           write_tag_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [DATA_W-1:0]              fill_data
);

    import cache_pkg::*;

    localparam int                CNT_W     = $clog2(BLOCK_WORDS);
    localparam logic [CNT_W:0]    REQ_FULL  = (CNT_W + 1)'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  RET_LAST  = CNT_W'(BLOCK_WORDS - 1);
    // Byte offset within a block spans one bit more than the word offset.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

    fill_state_t       state_r;
    fill_state_t       state_nx_s;
    logic [CNT_W:0]    req_cnt_r;
    logic [CNT_W:0]    req_cnt_nx_s;
    logic [CNT_W-1:0]  ret_cnt_r;
    logic [CNT_W-1:0]  ret_cnt_nx_s;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] base_nx_s;
    logic [ADDR_W-1:0] req_off_s;

    // Base is block aligned, so OR-ing the word offset never carries out of the block.
    assign req_off_s = ADDR_W'({req_cnt_r[CNT_W-1:0], 1'b0});

    // Stall is raised in the miss cycle itself and held low while reset is asserted.
    assign fsm_busy = rst_n & ((state_r == FILL) | ((state_r == IDLE) & miss_detected));

    // State, counters and latched block base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            req_cnt_r <= '0;
            ret_cnt_r <= '0;
            base_r    <= '0;
        end else begin
            state_r   <= state_nx_s;
            req_cnt_r <= req_cnt_nx_s;
            ret_cnt_r <= ret_cnt_nx_s;
            base_r    <= base_nx_s;
        end
    end

    // Next-state, counter updates and the request/write strobes.
    always_comb begin
        state_nx_s       = state_r;
        req_cnt_nx_s     = req_cnt_r;
        ret_cnt_nx_s     = ret_cnt_r;
        base_nx_s        = base_r;
        mem_req          = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_word        = '0;
        fill_data        = '0;

        case (state_r)
            IDLE: begin
                if (miss_detected) begin
                    base_nx_s    = miss_address & BASE_MASK;
                    req_cnt_nx_s = '0;
                    ret_cnt_nx_s = '0;
                    state_nx_s   = FILL;
                end else begin
                    state_nx_s   = IDLE;
                end
            end

            FILL: begin
                if (req_cnt_r < REQ_FULL) begin
                    mem_req        = 1'b1;
                    memory_address = base_r | req_off_s;
                    req_cnt_nx_s   = req_cnt_r + (CNT_W + 1)'(1);
                end else begin
                    mem_req        = 1'b0;
                end

                // Returns arrive in request order, so ret_cnt is the word offset.
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_word        = ret_cnt_r;
                    fill_data        = memory_data;
                    ret_cnt_nx_s     = ret_cnt_r + CNT_W'(1);
                    if (ret_cnt_r == RET_LAST) begin
                        write_tag_array = 1'b1;
                        state_nx_s      = DONE;
                    end else begin
                        state_nx_s      = FILL;
                    end
                end else begin
                    state_nx_s = FILL;
                end
            end

            DONE: begin
                state_nx_s = IDLE;
            end

            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm: a transaction-level model predicts every
// output each cycle, plus literal timing checks for the directed scenarios.
module tb_cache_fill_fsm;

    localparam int BW = 8;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LOGN = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic          memory_data_valid;
    logic [DW-1:0] memory_data;
    logic          fsm_busy;
    logic          mem_req;
    logic [AW-1:0] memory_address;
    logic          write_data_array;
    logic          write_tag_array;
    logic [2:0]    fill_word;
    logic [DW-1:0] fill_data;

    cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .fsm_busy(fsm_busy), .mem_req(mem_req), .memory_address(memory_address),
        .write_data_array(write_data_array), .write_tag_array(write_tag_array),
        .fill_word(fill_word), .fill_data(fill_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 4;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [15:0] data; } resp_t;
    resp_t rq[$];
    bit          stray_pend = 1'b0;
    logic [15:0] stray_data = 16'h0;

    // transaction-level model: is a fill open, how many requests/returns so far
    bit m_fill = 1'b0;
    bit m_done = 1'b0;
    int m_base = 0;
    int m_nreq = 0;
    int m_nbeat = 0;

    logic        l_req  [LOGN];
    logic [15:0] l_addr [LOGN];
    logic        l_wr   [LOGN];
    logic [2:0]  l_fw   [LOGN];
    logic        l_tag  [LOGN];
    logic        l_busy [LOGN];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // per-cycle prediction and comparison, then advance the model
    always @(negedge clk) begin
        logic        e_busy, e_req, e_wr, e_tag;
        logic [15:0] e_addr, e_fd;
        logic [2:0]  e_fw;
        e_busy = rst_n && (m_fill || (!m_done && miss_detected));
        e_req  = rst_n && m_fill && (m_nreq < BW);
        e_addr = e_req ? 16'(m_base + 2 * m_nreq) : 16'h0000;
        e_wr   = rst_n && m_fill && memory_data_valid;
        e_fw   = e_wr ? 3'(m_nbeat) : 3'd0;
        e_fd   = e_wr ? memory_data : 16'h0000;
        e_tag  = e_wr && (m_nbeat == BW - 1);
        chk("busy", {31'd0, fsm_busy}, {31'd0, e_busy});
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
        chk("mem_addr", {16'd0, memory_address}, {16'd0, e_addr});
        chk("wr_data", {31'd0, write_data_array}, {31'd0, e_wr});
        chk("wr_tag", {31'd0, write_tag_array}, {31'd0, e_tag});
        chk("fill_word", {29'd0, fill_word}, {29'd0, e_fw});
        chk("fill_data", {16'd0, fill_data}, {16'd0, e_fd});
        if (cyc < LOGN) begin
            l_req[cyc]  = mem_req;
            l_addr[cyc] = memory_address;
            l_wr[cyc]   = write_data_array;
            l_fw[cyc]   = fill_word;
            l_tag[cyc]  = write_tag_array;
            l_busy[cyc] = fsm_busy;
        end
        if (!rst_n) begin
            m_fill = 1'b0; m_done = 1'b0; m_base = 0; m_nreq = 0; m_nbeat = 0;
            rq.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_fill) begin
            if (m_nreq < BW) begin
                rq.push_back('{cyc + lat, 16'($urandom)});
                m_nreq++;
            end
            if (memory_data_valid) begin
                m_nbeat++;
                if (m_nbeat == BW) begin
                    m_fill = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (miss_detected) begin
            m_base  = int'(miss_address) & ~(2 * BW - 1);
            m_nreq  = 0;
            m_nbeat = 0;
            m_fill  = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = rq[0].data;
            void'(rq.pop_front());
        end else if (stray_pend) begin
            memory_data_valid = 1'b1;
            memory_data       = stray_data;
            stray_pend        = 1'b0;
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'h0000;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!m_fill && !m_done && rq.size() == 0) break;
            step();
        end
        chk("idle_timeout", {31'd0, m_fill | m_done}, 32'd0);
    endtask

    task automatic run_miss(input logic [15:0] addr, input int l, output int t0);
        lat = l;
        step();
        miss_detected = 1'b1;
        miss_address  = addr;
        t0 = cyc;
        step();
        miss_detected = 1'b0;
        wait_idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ts, n;
        rst_n = 1'b0;
        miss_detected = 1'b1;
        miss_address = 16'h1236;
        memory_data_valid = 1'b0;
        memory_data = 16'h0000;
        step(); step();
        chk("rst_busy", {31'd0, fsm_busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", {16'd0, memory_address}, 32'd0);
        miss_detected = 1'b0;
        rst_n = 1'b1;
        step(); step();

        // single miss, L=4
        run_miss(16'h1236, 4, t0);
        chk("t1_req_at_miss", {31'd0, l_req[t0]}, 32'd0);
        chk("t1_first_addr", {16'd0, l_addr[t0+1]}, 32'h1230);
        chk("t1_last_addr", {16'd0, l_addr[t0+8]}, 32'h123E);
        chk("t1_req_after", {31'd0, l_req[t0+9]}, 32'd0);
        chk("t1_wr_before", {31'd0, l_wr[t0+4]}, 32'd0);
        chk("t1_wr_first", {31'd0, l_wr[t0+5]}, 32'd1);
        chk("t1_fw_last", {29'd0, l_fw[t0+12]}, 32'd7);
        chk("t1_tag_early", {31'd0, l_tag[t0+11]}, 32'd0);
        chk("t1_tag", {31'd0, l_tag[t0+12]}, 32'd1);
        n = 0;
        for (int k = 0; k <= 13; k++) n += int'(l_busy[t0+k]);
        chk("t1_busy_cycles", n, 32'd13);
        chk("t1_busy_done", {31'd0, l_busy[t0+13]}, 32'd0);

        // miss held high through DONE
        lat = 4;
        step();
        miss_detected = 1'b1;
        miss_address  = 16'h2000;
        t0 = cyc;
        repeat (14) step();
        step();
        miss_detected = 1'b0;
        wait_idle();
        chk("t2_tag", {31'd0, l_tag[t0+12]}, 32'd1);
        chk("t2_busy_done", {31'd0, l_busy[t0+13]}, 32'd0);
        chk("t2_req_done", {31'd0, l_req[t0+13]}, 32'd0);
        chk("t2_busy_remiss", {31'd0, l_busy[t0+14]}, 32'd1);
        chk("t2_refetch_addr", {16'd0, l_addr[t0+15]}, 32'h2000);

        // miss address changes mid-fill
        lat = 4;
        step();
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        t0 = cyc;
        step(); miss_detected = 1'b0;
        step(); step();
        miss_detected = 1'b1;
        miss_address  = 16'h4000;
        step(); miss_detected = 1'b0;
        wait_idle();
        chk("t3_addr_mid", {16'd0, l_addr[t0+4]}, 32'h1236);
        chk("t3_addr_last", {16'd0, l_addr[t0+8]}, 32'h123E);

        // stray valid in IDLE
        step();
        stray_pend = 1'b1;
        stray_data = 16'hBEEF;
        step();
        ts = cyc;
        step(); step();
        chk("t4_stray_valid", {31'd0, memory_data_valid}, 32'd0);
        chk("t4_stray_wr", {31'd0, l_wr[ts]}, 32'd0);
        chk("t4_stray_busy", {31'd0, l_busy[ts+1]}, 32'd0);

        // reset after three returned words
        lat = 3;
        step();
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        step();
        miss_detected = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_nbeat >= 3) break;
            step();
        end
        chk("t5_three_beats", m_nbeat, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, fsm_busy}, 32'd0);
        chk("t5_rst_req", {31'd0, mem_req}, 32'd0);
        chk("t5_rst_wr", {31'd0, write_data_array}, 32'd0);
        chk("t5_rst_tag", {31'd0, write_tag_array}, 32'd0);
        chk("t5_rst_addr", {16'd0, memory_address}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        run_miss(16'hFFF8, 4, t0);
        chk("t5_top_first", {16'd0, l_addr[t0+1]}, 32'hFFF0);
        chk("t5_top_last", {16'd0, l_addr[t0+8]}, 32'hFFFE);
        chk("t5_top_tag", {31'd0, l_tag[t0+12]}, 32'd1);

        // latency 1 and 7
        for (int li = 0; li < 2; li++) begin
            int l;
            l = (li == 0) ? 1 : 7;
            run_miss(16'h0A5C, l, t0);
            chk("t6_last_wr", {31'd0, l_wr[t0+8+l]}, 32'd1);
            chk("t6_tag", {31'd0, l_tag[t0+8+l]}, 32'd1);
            n = 0;
            for (int k = 0; k <= 9 + l; k++) n += int'(l_tag[t0+k]);
            chk("t6_tag_count", n, 32'd1);
            chk("t6_busy_done", {31'd0, l_busy[t0+9+l]}, 32'd0);
        end

        // random traffic
        repeat (800) begin
            step();
            if (!m_fill && !m_done && rq.size() == 0) lat = $urandom_range(1, 7);
            miss_detected = ($urandom_range(0, 9) < 3);
            miss_address  = 16'($urandom);
            if (!m_fill && (m_done || !miss_detected) && $urandom_range(0, 9) == 0) begin
                stray_pend = 1'b1;
                stray_data = 16'($urandom);
            end
        end
        miss_detected = 1'b0;
        wait_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller for the pipeline's instruction and data caches: on a cache miss it fetches the full 8-word block from multi-cycle main memory, streams each returned word into the cache data array, and writes the tag when the last word lands. It sits between the cache lookup logic, which feeds the fetch and memory stages, and the pipelined main-memory model. One instance serves the I-cache and one serves the D-cache. The cache top arbitrates memory between them.

## Interface
Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block; power of two, ≥2
- ADDR_W, 16, byte-address width
- DATA_W, 16, word width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- miss_detected  in  1  level; cache lookup missed this cycle
- miss_address  in  ADDR_W  byte address of the missing access
- memory_data_valid  in  1  main memory returns a word this cycle
- memory_data  in  DATA_W  returned word
- fsm_busy  out  1  pipeline stall request
- mem_req  out  1  memory read request this cycle
- memory_address  out  ADDR_W  read address accompanying mem_req
- write_data_array  out  1  write fill_data into the data array at fill_word
- write_tag_array  out  1  write tag/valid for the block
- fill_word  out  log2(BLOCK_WORDS)  word offset within block being written
- fill_data  out  DATA_W  word being written

## Operation
- States are IDLE, FILL and DONE. Reset enters IDLE. Both counters reset to 0 and the base register resets to 0.
- IDLE
  - When miss_detected=1: latch base = miss_address with the low log2(BLOCK_WORDS)+1 bits cleared, clear req_cnt and ret_cnt, and go to FILL.
  - memory_data_valid is ignored.
- FILL
  - While req_cnt<BLOCK_WORDS: mem_req=1, memory_address=base+2·req_cnt, then increment req_cnt.
  - Once req_cnt=BLOCK_WORDS: mem_req=0 and memory_address=0.
  - Each memory_data_valid beat sets write_data_array=1, fill_word=ret_cnt, fill_data=memory_data, all combinational pass-through, then increments ret_cnt.
  - On the beat with ret_cnt=BLOCK_WORDS-1: also set write_tag_array=1 and go to DONE.
  - miss_address and miss_detected are ignored during FILL; the base stays latched.
- DONE
  - Lasts one cycle. All outputs are 0. miss_detected and memory_data_valid are ignored.
  - This gives the cache one cycle to re-lookup a hit without re-triggering.
  - Always goes to IDLE next.
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected). It is combinational, so the pipeline stalls in the same cycle as the miss.
- Default output values are mem_req=0, write_*=0, fill_word=0, fill_data=0, memory_address=0. These are also the values held during reset.
- Memory returns data in request order. Any valid beat in excess of BLOCK_WORDS is not possible within FILL and is ignored in IDLE/DONE.
- Width rules:
  - req_cnt is log2(BLOCK_WORDS)+1 bits, so it saturates at BLOCK_WORDS.
  - ret_cnt is log2(BLOCK_WORDS) bits.
  - Address adds never carry past the block, so the highest block 0xFFF0 fetches 0xFFF0..0xFFFE with no wrap.
- rst_n assertion mid-FILL: the block immediately returns to IDLE with all outputs 0. Outstanding memory returns are dropped, and the cache tag is not written.

## Timing
- A miss sampled in IDLE at cycle 0 puts the block in FILL at cycle 1.
- mem_req is high for cycles 1..BLOCK_WORDS, one address per cycle, with no bubbles.
- With memory latency L (word k valid L cycles after its request):
  - data writes occur at cycles 1+L .. BLOCK_WORDS+L
  - write_tag_array occurs in the same cycle as the last data write
  - DONE at BLOCK_WORDS+L+1
  - IDLE at BLOCK_WORDS+L+2
- Miss penalty for 8 words and L=4: fsm_busy is high in cycles 0..12 (13 cycles).
- Back-to-back misses: a new miss is accepted no earlier than the IDLE cycle following DONE.

## Structure
- Package cache_pkg holds:
  - the fill_state_t enum {IDLE, FILL, DONE}
  - the BLOCK_WORDS/OFFSET_W constants
  - the tag/index/offset field widths shared with the cache arrays
- No sub-module: the counters, base register and FSM are inline. The I/D arbitration lives in the cache top, not here.

## Test plan
- Single miss: miss_address=0x1236, memory with L=4.
  - Required requests: 0x1230,0x1232,…,0x123E at cycles 1..8.
  - Required writes: fill_word 0..7 at cycles 5..12.
  - Required tag: write_tag_array at cycle 12 only.
  - Required busy: fsm_busy high for 13 cycles, then low in DONE.
- Held miss: miss_detected kept high through DONE. Required: no second fill starts, and a re-miss is accepted only in the following IDLE.
- Address change: miss_address changed to 0x4000 mid-FILL. Required: all requests and writes stay in block 0x1230.
- Stray valid: memory_data_valid pulsed in IDLE with data 0xBEEF. Required: write_data_array=0 and no state change.
- Reset during fill: rst_n pulled low after 3 data beats. Required: all outputs 0 asynchronously, no tag write, and a subsequent miss on 0xFFF8 fetches 0xFFF0..0xFFFE correctly.
- Variable latency: L=1 and L=7. Required: the tag write coincides with the 8th valid beat in both cases.
